// File: rtl/led_p_pkg.sv
// -----------------------------------------------------------------------------
// led_p_pkg
// Shared definitions for the PWM/blink LED peripheral: the register map.
// Addresses are plain integers; each user casts them to its own address width.
// -----------------------------------------------------------------------------
package led_p_pkg;

   localparam int unsigned LED_VAL_A      = 0;  // static on/off per LED
   localparam int unsigned LED_PWM_A      = 1;  // 1 = LED gated by PWM
   localparam int unsigned LED_BLINK_A    = 2;  // 1 = LED gated by blink phase
   localparam int unsigned PWM_DUTY_A     = 3;  // global PWM duty
   localparam int unsigned BLINK_DIV_A    = 4;  // blink half-period in clk cycles
   localparam int unsigned STATUS_A       = 5;  // read-only {phase, pwm_cnt}
   localparam int unsigned SCRATCH_BASE_A = 6;  // first full-width scratch register

endpackage

// File: rtl/led_pwm_gen.sv
// -----------------------------------------------------------------------------
// led_pwm_gen
// Timing generator for the LED peripheral: a free-running PWM counter with a
// duty comparator, and a blink divider producing a square-wave phase.
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   synchronous reset, active-low
//   duty     in   PWM_W   global PWM duty
//   div      in   DIV_W   blink half-period in clk cycles (0 = no blinking)
//   div_wr   in   1       divider register is being written this cycle
//   pwm_on   out  1       pwm_cnt < duty
//   phase    out  1       blink phase, 1 = LEDs on
//   pwm_cnt  out  PWM_W   current PWM counter value
// -----------------------------------------------------------------------------
module led_pwm_gen
   import led_p_pkg::*;
#(
   parameter int PWM_W = 8,
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [PWM_W-1:0] duty,
   input  logic [DIV_W-1:0] div,
   input  logic             div_wr,
   output logic             pwm_on,
   output logic             phase,
   output logic [PWM_W-1:0] pwm_cnt
);

   logic [DIV_W-1:0] blink_cnt;

   // Free-running counter; wraps naturally at 2**PWM_W. Writes never touch it.
   always_ff @(posedge clk) begin
      if (!rst) begin
         pwm_cnt <= '0;
      end else begin
         pwm_cnt <= pwm_cnt + PWM_W'(1);
      end
   end

   // Strict compare: duty 0 is always off, the top duty leaves one off slot.
   assign pwm_on = (pwm_cnt < duty);

   // A divider write restarts the blink period with the LEDs on, and takes
   // priority over a wrap landing on the same edge. The >= compare keeps the
   // counter bounded even if it were ever above a new, smaller divider.
   always_ff @(posedge clk) begin
      if (!rst) begin
         blink_cnt <= '0;
         phase     <= 1'b1;
      end else if (div_wr) begin
         blink_cnt <= '0;
         phase     <= 1'b1;
      end else if (div == '0) begin
         blink_cnt <= '0;
         phase     <= 1'b1;
      end else if (blink_cnt >= div - DIV_W'(1)) begin
         blink_cnt <= '0;
         phase     <= ~phase;
      end else begin
         blink_cnt <= blink_cnt + DIV_W'(1);
      end
   end

endmodule

// File: rtl/led_pwm_p.sv
// -----------------------------------------------------------------------------
// led_pwm_p
// Memory-mapped LED peripheral with per-LED static value, PWM dimming and
// blinking. Holds the register file, the registered read port and the LED
// output flop; timing comes from led_pwm_gen.
//
// Ports
//   clk    in   rising-edge clock
//   rst    in   synchronous reset, active-low (0 = reset)
//   wea    in   1        write enable for addra/dina
//   addra  in   ADDR_W   register address
//   dina   in   DATA_W   write data
//   douta  out  DATA_W   registered read data (1-cycle latency, old value on
//                        read-during-write)
//   led    out  NUM_LED  registered LED drive, 1 = on
// -----------------------------------------------------------------------------
module led_pwm_p
   import led_p_pkg::*;
#(
   parameter int NUM_LED = 8,
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 4,
   parameter int PWM_W   = 8,
   parameter int DIV_W   = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               wea,
   input  logic [ADDR_W-1:0]  addra,
   input  logic [DATA_W-1:0]  dina,
   output logic [DATA_W-1:0]  douta,
   output logic [NUM_LED-1:0] led
);

   localparam int NUM_REG = 2 ** ADDR_W;

   localparam logic [ADDR_W-1:0] A_VAL    = ADDR_W'(LED_VAL_A);
   localparam logic [ADDR_W-1:0] A_PWM    = ADDR_W'(LED_PWM_A);
   localparam logic [ADDR_W-1:0] A_BLINK  = ADDR_W'(LED_BLINK_A);
   localparam logic [ADDR_W-1:0] A_DUTY   = ADDR_W'(PWM_DUTY_A);
   localparam logic [ADDR_W-1:0] A_DIV    = ADDR_W'(BLINK_DIV_A);
   localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(STATUS_A);

   logic [DATA_W-1:0]  regs [NUM_REG];
   logic [DATA_W-1:0]  status_word;
   logic [DATA_W-1:0]  rd_word;
   logic [NUM_LED-1:0] led_next;
   logic               pwm_on;
   logic               phase;
   logic [PWM_W-1:0]   pwm_cnt;
   logic               div_wr;

   // Mask with the low n bits set; works for any n up to DATA_W.
   function automatic logic [DATA_W-1:0] low_mask(input int n);
      logic [DATA_W-1:0] m;
      m = '0;
      for (int i = 0; i < DATA_W; i++) begin
         m[i] = (i < n);
      end
      return m;
   endfunction

   // Bits each register actually stores. Masking on write means reads need
   // no further masking.
   function automatic logic [DATA_W-1:0] field_mask(input logic [ADDR_W-1:0] a);
      if (a == A_VAL || a == A_PWM || a == A_BLINK) begin
         return low_mask(NUM_LED);
      end else if (a == A_DUTY) begin
         return low_mask(PWM_W);
      end else if (a == A_DIV) begin
         return low_mask(DIV_W);
      end else if (a == A_STATUS) begin
         return '0;
      end else begin
         return '1;
      end
   endfunction

   // Register file. STATUS is never written; its slot stays at reset value.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NUM_REG; i++) begin
            regs[i] <= '0;
         end
      end else if (wea && addra != A_STATUS) begin
         regs[addra] <= dina & field_mask(addra);
      end
   end

   // The divider register changes on this same edge; the generator sees the
   // strobe and restarts rather than acting on the old divider value.
   assign div_wr = wea && (addra == A_DIV);

   led_pwm_gen #(
      .PWM_W (PWM_W),
      .DIV_W (DIV_W)
   ) u_gen (
      .clk     (clk),
      .rst     (rst),
      .duty    (regs[A_DUTY][PWM_W-1:0]),
      .div     (regs[A_DIV][DIV_W-1:0]),
      .div_wr  (div_wr),
      .pwm_on  (pwm_on),
      .phase   (phase),
      .pwm_cnt (pwm_cnt)
   );

   always_comb begin
      status_word              = '0;
      status_word[PWM_W-1:0]   = pwm_cnt;
      status_word[PWM_W]       = phase;
   end

   always_comb begin
      rd_word = regs[addra];
      if (addra == A_STATUS) begin
         rd_word = status_word;
      end
   end

   // Each enable bit selects whether its gate applies to that LED.
   assign led_next = regs[A_VAL][NUM_LED-1:0]
                   & (~regs[A_PWM][NUM_LED-1:0]   | {NUM_LED{pwm_on}})
                   & (~regs[A_BLINK][NUM_LED-1:0] | {NUM_LED{phase}});

   // Read port and LED drive are sampled from pre-edge register contents,
   // which gives old-data read-during-write and a two-edge write-to-LED path.
   always_ff @(posedge clk) begin
      if (!rst) begin
         douta <= '0;
         led   <= '0;
      end else begin
         douta <= rd_word;
         led   <= led_next;
      end
   end

endmodule
